// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the PC fetch sequencer.
//   AW            instruction address width
//   RESET_VECTOR  value the PC register itself resets to
//   addr_t        instruction address type
//   seq_state_e   sequencer FSM states
//   redirect_t    arbitrated redirect request {vld, target, misaligned}
package pc_sequencer_pkg;

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] RESET_VECTOR = '0;

    typedef logic [AW-1:0] addr_t;

    typedef enum logic [1:0] {
        SEQ_BOOT   = 2'd0,
        SEQ_FETCH  = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic  vld;
        addr_t target;      // already word-aligned
        logic  misaligned;  // raw target had bit[1] set
    } redirect_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the sequencer's hazard, EX/CSR, imem and PC-control
// signals.
//   master : the sequencer (consumes requests, drives PC control and flushes)
//   slave  : the surrounding pipeline / PC / imem
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic  stall_i;
    logic  br_taken_i;
    addr_t br_target_i;
    logic  trap_i;
    addr_t trap_vector_i;
    logic  mret_i;
    addr_t mepc_i;
    logic  halt_i;
    logic  imem_ack_i;
    logic  imem_req_o;
    logic  pc_wr_enable_o;
    logic  pc_jump_enable_o;
    addr_t pc_jump_addr_o;
    logic  flush_if_o;
    logic  flush_id_o;
    logic  misalign_o;
    logic  halted_o;

    modport master (
        input  stall_i, br_taken_i, br_target_i, trap_i, trap_vector_i,
               mret_i, mepc_i, halt_i, imem_ack_i,
        output imem_req_o, pc_wr_enable_o, pc_jump_enable_o, pc_jump_addr_o,
               flush_if_o, flush_id_o, misalign_o, halted_o
    );

    modport slave (
        output stall_i, br_taken_i, br_target_i, trap_i, trap_vector_i,
               mret_i, mepc_i, halt_i, imem_ack_i,
        input  imem_req_o, pc_wr_enable_o, pc_jump_enable_o, pc_jump_addr_o,
               flush_if_o, flush_id_o, misalign_o, halted_o
    );

endinterface

// File: rtl/pc_sequencer_arbiter.sv
// redirect_arbiter: combinational fixed-priority select of redirect sources,
// trap > mret > taken branch.
//   trap/trap_vector, mret/mepc, br_taken/br_target : raw requests
//   redirect : {vld, word-aligned target, misaligned (raw bit[1])}
module redirect_arbiter
    import pc_sequencer_pkg::*;
(
    input  logic      trap,
    input  addr_t     trap_vector,
    input  logic      mret,
    input  addr_t     mepc,
    input  logic      br_taken,
    input  addr_t     br_target,
    output redirect_t redirect
);

    addr_t sel;
    logic  unused_sel_bit0;

    always_comb begin
        sel = '0;
        if (trap) begin
            sel = trap_vector;
        end else if (mret) begin
            sel = mepc;
        end else if (br_taken) begin
            sel = br_target;
        end
        redirect.vld        = trap | mret | br_taken;
        redirect.target     = {sel[AW-1:2], 2'b00};
        redirect.misaligned = redirect.vld & sel[1];
    end

    // Only bit[1] is diagnosed; bit[0] is dropped by the forced alignment.
    assign unused_sel_bit0 = sel[0];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC controller. Sequences PC writes against the
// imem handshake and hazard stalls, arbitrates trap/mret/branch redirects,
// holds a single pending redirect while the PC cannot advance, and issues
// pipeline flushes.
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : pc_sequencer_if.master (requests in, PC control / flush out)
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    seq_state_e state, state_next;
    logic       pending_vld, pending_vld_next;
    addr_t      pending_addr, pending_addr_next;
    logic       misalign_q, misalign_next;

    redirect_t  raw;
    logic       advance;
    logic       eff_vld;
    addr_t      eff_target;

    redirect_arbiter u_arbiter (
        .trap        (bus.trap_i),
        .trap_vector (bus.trap_vector_i),
        .mret        (bus.mret_i),
        .mepc        (bus.mepc_i),
        .br_taken    (bus.br_taken_i),
        .br_target   (bus.br_target_i),
        .redirect    (raw)
    );

    assign advance    = bus.imem_ack_i & ~bus.stall_i;
    // A fresh request always beats whatever is parked in the pending slot.
    assign eff_vld    = raw.vld | pending_vld;
    assign eff_target = raw.vld ? raw.target : pending_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= SEQ_BOOT;
            pending_vld  <= 1'b0;
            pending_addr <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state        <= state_next;
            pending_vld  <= pending_vld_next;
            pending_addr <= pending_addr_next;
            misalign_q   <= misalign_next;
        end
    end

    always_comb begin
        state_next           = state;
        pending_vld_next     = pending_vld;
        pending_addr_next    = pending_addr;
        misalign_next        = 1'b0;
        bus.imem_req_o       = 1'b0;
        bus.pc_wr_enable_o   = 1'b0;
        bus.pc_jump_enable_o = 1'b0;
        bus.pc_jump_addr_o   = '0;
        bus.flush_if_o       = 1'b0;
        bus.flush_id_o       = 1'b0;

        unique case (state)
            SEQ_BOOT: begin
                state_next = SEQ_FETCH;
            end

            SEQ_FETCH: begin
                bus.imem_req_o = 1'b1;
                bus.flush_if_o = eff_vld;
                bus.flush_id_o = raw.vld;
                misalign_next  = raw.misaligned;
                if (advance) begin
                    bus.pc_wr_enable_o = 1'b1;
                    if (eff_vld) begin
                        // Redirect (same-cycle or pending) is consumed; a
                        // concurrent halt request is dropped.
                        bus.pc_jump_enable_o = 1'b1;
                        bus.pc_jump_addr_o   = eff_target;
                        pending_vld_next     = 1'b0;
                    end else if (bus.halt_i) begin
                        state_next = SEQ_HALTED;
                    end
                end else if (raw.vld) begin
                    pending_vld_next  = 1'b1;
                    pending_addr_next = raw.target;
                end
            end

            SEQ_HALTED: begin
                // Only a trap wakes the core; it bypasses the imem handshake.
                if (bus.trap_i) begin
                    bus.pc_wr_enable_o   = 1'b1;
                    bus.pc_jump_enable_o = 1'b1;
                    bus.pc_jump_addr_o   = raw.target;
                    bus.flush_if_o       = 1'b1;
                    bus.flush_id_o       = 1'b1;
                    misalign_next        = raw.misaligned;
                    state_next           = SEQ_FETCH;
                end
            end

            default: begin
                state_next = SEQ_BOOT;
            end
        endcase
    end

    assign bus.misalign_o = misalign_q;
    assign bus.halted_o   = (state == SEQ_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a PC-write scoreboard. Stimulus
// pushes the expected PC write {cycle, jump, addr} for each cycle it expects
// one; a negedge monitor pops and compares whenever the DUT writes the PC,
// and flags writes that are missing or unexpected. Status outputs (req,
// flushes, halted, misalign) are checked inline.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pc_sequencer_if bus();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        jump;
        addr_t       addr;
    } wr_exp_t;

    wr_exp_t     sb[$];
    wr_exp_t     head;
    int unsigned cyc_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.pc_wr_enable_o) begin
            n_cmp++;
            if (sb.size() == 0 || sb[0].cyc != cyc_cnt) begin
                n_err++;
                $display("FAIL wr_unexpected cyc=%0d: got jump=%0b addr=%h, required no write",
                         cyc_cnt, bus.pc_jump_enable_o, bus.pc_jump_addr_o);
            end else begin
                head = sb.pop_front();
                if (bus.pc_jump_enable_o !== head.jump || bus.pc_jump_addr_o !== head.addr) begin
                    n_err++;
                    $display("FAIL wr_value cyc=%0d: got jump=%0b addr=%h, required jump=%0b addr=%h",
                             cyc_cnt, bus.pc_jump_enable_o, bus.pc_jump_addr_o, head.jump, head.addr);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc == cyc_cnt) begin
            head = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL wr_missing cyc=%0d: got no write, required jump=%0b addr=%h",
                     cyc_cnt, head.jump, head.addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic expect_wr(input logic j, input addr_t a);
        sb.push_back('{cyc: cyc_cnt, jump: j, addr: a});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.stall_i    = 1'b0;
        bus.br_taken_i = 1'b0;
        bus.trap_i     = 1'b0;
        bus.mret_i     = 1'b0;
        bus.halt_i     = 1'b0;
    endtask

    initial begin
        clear_reqs();
        bus.br_target_i   = '0;
        bus.trap_vector_i = '0;
        bus.mepc_i        = '0;
        bus.imem_ack_i    = 1'b0;

        // Reset state
        #2;
        chk("rst_req",      32'(bus.imem_req_o),       0);
        chk("rst_wr",       32'(bus.pc_wr_enable_o),   0);
        chk("rst_jump",     32'(bus.pc_jump_enable_o), 0);
        chk("rst_addr",     bus.pc_jump_addr_o,        0);
        chk("rst_flush_if", 32'(bus.flush_if_o),       0);
        chk("rst_flush_id", 32'(bus.flush_id_o),       0);
        chk("rst_misalign", 32'(bus.misalign_o),       0);
        chk("rst_halted",   32'(bus.halted_o),         0);
        tick();
        tick();

        // 1: release reset, one BOOT cycle, then sequential fetch
        rst = 1'b1;
        bus.imem_ack_i = 1'b1;
        settle();
        chk("boot_req", 32'(bus.imem_req_o), 0);
        chk("boot_wr",  32'(bus.pc_wr_enable_o), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_wr(1'b0, 32'h0);
            settle();
            chk("t1_req", 32'(bus.imem_req_o), 1);
        end

        // 2: branch 0x100 held pending while no ack
        tick();
        bus.imem_ack_i  = 1'b0;
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h100;
        settle();
        chk("t2_flush_if0", 32'(bus.flush_if_o), 1);
        chk("t2_flush_id0", 32'(bus.flush_id_o), 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.br_taken_i = 1'b0;
            settle();
            chk("t2_flush_if_pend", 32'(bus.flush_if_o), 1);
            chk("t2_flush_id_pend", 32'(bus.flush_id_o), 0);
        end
        tick();
        bus.imem_ack_i = 1'b1;
        expect_wr(1'b1, 32'h100);
        settle();
        chk("t2_flush_if_apply", 32'(bus.flush_if_o), 1);
        tick();
        expect_wr(1'b0, 32'h0);
        settle();
        chk("t2_pending_cleared", 32'(bus.flush_if_o), 0);

        // 3: trap beats branch in the same cycle
        tick();
        bus.trap_i        = 1'b1;
        bus.trap_vector_i = 32'h80;
        bus.br_taken_i    = 1'b1;
        bus.br_target_i   = 32'h200;
        expect_wr(1'b1, 32'h80);
        settle();
        chk("t3_flush_id", 32'(bus.flush_id_o), 1);
        tick();
        clear_reqs();
        expect_wr(1'b0, 32'h0);
        settle();

        // 4: pending branch overridden by mret under stall
        tick();
        bus.stall_i     = 1'b1;
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h200;
        settle();
        chk("t4_flush_if", 32'(bus.flush_if_o), 1);
        tick();
        bus.br_taken_i = 1'b0;
        bus.mret_i     = 1'b1;
        bus.mepc_i     = 32'h40;
        settle();
        chk("t4_flush_id_mret", 32'(bus.flush_id_o), 1);
        tick();
        bus.mret_i  = 1'b0;
        bus.stall_i = 1'b0;
        expect_wr(1'b1, 32'h40);
        settle();
        tick();
        expect_wr(1'b0, 32'h0);
        settle();
        chk("t4_pending_cleared", 32'(bus.flush_if_o), 0);

        // 5: misaligned branch target
        tick();
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h102;
        expect_wr(1'b1, 32'h100);
        settle();
        chk("t5_misalign_same", 32'(bus.misalign_o), 0);
        tick();
        bus.br_taken_i = 1'b0;
        expect_wr(1'b0, 32'h0);
        settle();
        chk("t5_misalign_pulse", 32'(bus.misalign_o), 1);
        tick();
        expect_wr(1'b0, 32'h0);
        settle();
        chk("t5_misalign_gone", 32'(bus.misalign_o), 0);

        // 6: halt, idle with ignored requests, trap wake-up
        tick();
        bus.halt_i = 1'b1;
        expect_wr(1'b0, 32'h0);
        settle();
        chk("t6_not_yet_halted", 32'(bus.halted_o), 0);
        tick();
        bus.halt_i = 1'b0;
        settle();
        chk("t6_halted", 32'(bus.halted_o), 1);
        chk("t6_req_off", 32'(bus.imem_req_o), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.stall_i     = (i % 2) == 1;
            bus.br_taken_i  = (i == 2);
            bus.br_target_i = 32'h300;
            bus.mret_i      = (i == 3);
            settle();
            chk("t6_idle_wr", 32'(bus.pc_wr_enable_o), 0);
            chk("t6_idle_halted", 32'(bus.halted_o), 1);
        end
        tick();
        clear_reqs();
        bus.trap_i        = 1'b1;
        bus.trap_vector_i = 32'h80;
        expect_wr(1'b1, 32'h80);
        settle();
        chk("t6_wake_flush_id", 32'(bus.flush_id_o), 1);
        tick();
        bus.trap_i = 1'b0;
        expect_wr(1'b0, 32'h0);
        settle();
        chk("t6_resumed", 32'(bus.halted_o), 0);
        chk("t6_resumed_req", 32'(bus.imem_req_o), 1);

        // Reset while a redirect is pending
        tick();
        bus.imem_ack_i  = 1'b0;
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h300;
        settle();
        chk("rp_flush_raw", 32'(bus.flush_if_o), 1);
        tick();
        bus.br_taken_i = 1'b0;
        settle();
        chk("rp_flush_pend", 32'(bus.flush_if_o), 1);
        rst = 1'b0;
        #1;
        chk("rp_async_flush", 32'(bus.flush_if_o), 0);
        chk("rp_async_req",   32'(bus.imem_req_o), 0);
        tick();
        rst = 1'b1;
        bus.imem_ack_i = 1'b1;
        settle();
        chk("rp_boot_wr", 32'(bus.pc_wr_enable_o), 0);
        tick();
        expect_wr(1'b0, 32'h0);
        settle();
        chk("rp_no_pending", 32'(bus.flush_if_o), 0);
        tick();
        settle();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
